// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    // Controller states; encodings are fixed so they read the same in waveforms.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Legal WIDTH range for the controller.
    localparam int unsigned WidthMin = 1;
    localparam int unsigned WidthMax = 64;

endpackage

// File: rtl/serial_sub_bit.sv
// One-bit full-subtractor cell: diff = a - b - borrow, purely combinational.
module serial_sub_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    // Difference and borrow-out of a single bit position.
    always_comb begin
        diff_o   = a_i ^ b_i ^ borrow_i;
        borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: result = a - b - borrow_in, one bit per cycle LSB-first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             overflow_o,
`endif
    output logic             busy_o
);

    // Extra counter bit so WIDTH=64 never wraps.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_width_check
        $error("serial_subtractor_ctrl: WIDTH must be within 1..64");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic             bit_diff;
    logic             bit_borrow;
    logic [WIDTH:0]   diff_shift;

    serial_sub_bit u_cell (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .borrow_i (br_q),
        .diff_o   (bit_diff),
        .borrow_o (bit_borrow)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB-first stream lines up.
    assign diff_shift = {bit_diff, diff_q};

    // Next-state, datapath sequencing and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        br_d        = br_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = borrow_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy_o = 1'b1;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = bit_borrow;
                cnt_d  = cnt_q + CntW'(1);
                diff_d = diff_shift[WIDTH:1];
                if (cnt_q == CntLast) begin
                    // Operand LSBs are the original MSBs on the final cycle.
                    bout_d  = bit_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (a_q[0] != b_q[0]) && (bit_diff != a_q[0]);
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8 plus a WIDTH=1 instance).
module tb_serial_subtractor_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, diff;
    logic         borrow_in, borrow_out, busy;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    logic in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a1, b1, diff1;
    logic bi1, bo1, busy1;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ovf1;
`endif

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .borrow_i    (borrow_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .diff_o      (diff),
        .borrow_o    (borrow_out),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .overflow_o  (ovf),
`endif
        .busy_o      (busy)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_valid_i  (in_valid1),
        .in_ready_o  (in_ready1),
        .a_i         (a1),
        .b_i         (b1),
        .borrow_i    (bi1),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready1),
        .diff_o      (diff1),
        .borrow_o    (bo1),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .overflow_o  (ovf1),
`endif
        .busy_o      (busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   last_acc = 0;
    bit   rnd_ready = 1'b0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        exp_t e;
        int   s;
        s      = int'(x) - int'(y) - int'(z);
        e.diff = s[W-1:0];
        e.bo   = (int'(x) < int'(y) + int'(z));
        e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
        e.due  = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high; caller decides when to drop it.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        exp_t e;
        int   n = 0;
        a = x; b = y; borrow_in = z; in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        e        = model(x, y, z);
        e.due    = cyc + 1 + int'(W);
        last_acc = cyc + 1;
        sbq.push_back(e);
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 400) begin
            tick();
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'(0));
    endtask

    // Monitor: compares presented results against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                if (!prev_ov) chk("latency", 64'(cyc), 64'(sbq[0].due));
                chk("diff", 64'(diff), 64'(sbq[0].diff));
                chk("borrow_out", 64'(borrow_out), 64'(sbq[0].bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("overflow", 64'(ovf), 64'(sbq[0].ovf));
`endif
                chk("in_ready_low_in_done", 64'(in_ready), 64'(0));
                chk("busy_in_done", 64'(busy), 64'(1));
                if (out_ready) void'(sbq.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    // Random consumer backpressure, changed just after the edge.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int        hs;
        int        s1;
        logic      x1, y1, z1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; borrow_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; bi1 = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_diff", 64'(diff), 64'(0));
        chk("rst_borrow", 64'(borrow_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed cases
        send(8'h05, 8'h03, 1'b0); in_valid = 1'b0; wait_idle();
        send(8'h03, 8'h05, 1'b0); in_valid = 1'b0; wait_idle();
        send(8'h00, 8'h00, 1'b1); in_valid = 1'b0; wait_idle();
        send(8'h80, 8'h01, 1'b0); in_valid = 1'b0; wait_idle();
        send(8'hFF, 8'hFF, 1'b1); in_valid = 1'b0; wait_idle();
        send(8'h00, 8'hFF, 1'b0); in_valid = 1'b0; wait_idle();
        send(8'h7F, 8'h80, 1'b0); in_valid = 1'b0; wait_idle();

        // Backpressure with a second request held pending
        out_ready = 1'b0;
        hs = 0;
        send(8'h21, 8'h07, 1'b0);
        fork
            begin
                send(8'h10, 8'h01, 1'b0);
                in_valid = 1'b0;
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    tick();
                    n++;
                end
                chk("bp_valid_seen", 64'(out_valid), 64'(1));
                repeat (5) begin
                    tick();
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                    chk("bp_hold_valid", 64'(out_valid), 64'(1));
                    chk("bp_hold_diff", 64'(diff), 64'(8'h1A));
                end
                out_ready = 1'b1;
                hs = cyc + 1;
            end
        join
        chk("bp_accept_cycle", 64'(last_acc), 64'(hs + 1));
        wait_idle();

        // Reset in the middle of RUN
        send(8'h12, 8'h34, 1'b0); in_valid = 1'b0;
        tick(); tick();
        chk("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_diff", 64'(diff), 64'(0));
        chk("abort_borrow", 64'(borrow_out), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        sbq.delete();
        tick();
        rst = 1'b0;
        repeat (W + 3) tick();
        send(8'hAA, 8'h55, 1'b0); in_valid = 1'b0; wait_idle();

        // Randomised traffic with random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        rnd_ready = 1'b0;
        tick();
        out_ready = 1'b1;

        // WIDTH=1 instance: all operand combinations
        for (int i = 0; i < 8; i++) begin
            x1 = i[2]; y1 = i[1]; z1 = i[0];
            s1 = int'(x1) - int'(y1) - int'(z1);
            a1 = x1; b1 = y1; bi1 = z1; in_valid1 = 1'b1;
            chk("w1_in_ready", 64'(in_ready1), 64'(1));
            tick();
            in_valid1 = 1'b0;
            chk("w1_busy", 64'(busy1), 64'(1));
            tick();
            chk("w1_out_valid", 64'(out_valid1), 64'(1));
            chk("w1_diff", 64'(diff1), 64'(s1[0]));
            chk("w1_borrow", 64'(bo1), 64'(int'(x1) < int'(y1) + int'(z1)));
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("w1_overflow", 64'(ovf1), 64'((x1 != y1) && (s1[0] != x1)));
`endif
            tick();
            chk("w1_valid_drop", 64'(out_valid1), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
